// File: rtl/interboard_receiver.sv
// ---------------------------------------------------------------------------
// interboard_receiver
//   Receives 4-word (6-bit) messages from another board over an asynchronous
//   4-phase request/ack handshake, decodes the fields and pulses
//   interboard_en (normal message) or interboard_rst (remote reset message).
//   A watchdog aborts a stalled message and pulses rx_error.
//
// Ports
//   clk                  system clock
//   rst                  asynchronous active-high reset
//   request              sender strobe (asynchronous to clk)
//   interboard_data[5:0] sender word, stable while request is high
//   ack                  receiver acknowledge
//   interboard_en        1-cycle pulse: new non-reset message on field outputs
//   interboard_rst       1-cycle pulse: RST_TYPE message received
//   interboard_msg_type  decoded message type        (w0[5:2])
//   interboard_move_dir  decoded move direction      (w0[1])
//   interboard_block_y   decoded block row           (w1[5:3])
//   interboard_sel_len   decoded selection length    (w1[2:0])
//   interboard_card      decoded card id             (w2[5:0])
//   interboard_block_x   decoded block column        (w3[5:1])
//   rx_error             1-cycle pulse on a watchdog abort
// ---------------------------------------------------------------------------
module interboard_receiver #(
  parameter int          TIMEOUT  = 1_000_000,
  parameter logic [3:0]  RST_TYPE = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       request,
  input  logic [5:0] interboard_data,
  output logic       ack,
  output logic       interboard_en,
  output logic       interboard_rst,
  output logic [3:0] interboard_msg_type,
  output logic       interboard_move_dir,
  output logic [4:0] interboard_block_x,
  output logic [2:0] interboard_block_y,
  output logic [5:0] interboard_card,
  output logic [2:0] interboard_sel_len,
  output logic       rx_error
);

  typedef enum logic [1:0] {WAIT_REQ, WAIT_REL, DONE} state_t;

  localparam logic [19:0] WDOG_LIMIT = 20'(TIMEOUT - 1);

  // Synchronizers
  logic       req_meta_q, req_s_q;
  logic [5:0] data_meta_q, data_s_q;

  // FSM and datapath state
  state_t          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [3:0][5:0] words_q, words_d;
  logic [19:0]     wdog_q, wdog_d;
  logic            stale_q, stale_d;
  logic            ack_q, ack_d;
  logic            en_q, en_d;
  logic            rstp_q, rstp_d;
  logic            err_q, err_d;
  logic [3:0]      msg_type_q, msg_type_d;
  logic            move_dir_q, move_dir_d;
  logic [4:0]      block_x_q, block_x_d;
  logic [2:0]      block_y_q, block_y_d;
  logic [5:0]      card_q, card_d;
  logic [2:0]      sel_len_q, sel_len_d;

  logic wdog_run, timeout;

  // State register
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; the word store is reset too so no X leaks into fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_meta_q  <= 1'b0;
      req_s_q     <= 1'b0;
      data_meta_q <= '0;
      data_s_q    <= '0;
      state_q     <= WAIT_REQ;
      cnt_q       <= '0;
      words_q     <= '0;
      wdog_q      <= '0;
      stale_q     <= 1'b0;
      ack_q       <= 1'b0;
      en_q        <= 1'b0;
      rstp_q      <= 1'b0;
      err_q       <= 1'b0;
      msg_type_q  <= '0;
      move_dir_q  <= 1'b0;
      block_x_q   <= '0;
      block_y_q   <= '0;
      card_q      <= '0;
      sel_len_q   <= '0;
    end else begin
      req_meta_q  <= request;
      req_s_q     <= req_meta_q;
      data_meta_q <= interboard_data;
      data_s_q    <= data_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      words_q     <= words_d;
      wdog_q      <= wdog_d;
      stale_q     <= stale_d;
      ack_q       <= ack_d;
      en_q        <= en_d;
      rstp_q      <= rstp_d;
      err_q       <= err_d;
      msg_type_q  <= msg_type_d;
      move_dir_q  <= move_dir_d;
      block_x_q   <= block_x_d;
      block_y_q   <= block_y_d;
      card_q      <= card_d;
      sel_len_q   <= sel_len_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every signal gets a default first so no path infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    words_d    = words_q;
    wdog_d     = wdog_q;
    stale_d    = stale_q;
    ack_d      = ack_q;
    en_d       = 1'b0;
    rstp_d     = 1'b0;
    err_d      = 1'b0;
    msg_type_d = msg_type_q;
    move_dir_d = move_dir_q;
    block_x_d  = block_x_q;
    block_y_d  = block_y_q;
    card_d     = card_q;
    sel_len_d  = sel_len_q;

    // Watchdog runs only while a message is in progress.
    wdog_run = (state_q == WAIT_REL) || ((state_q == WAIT_REQ) && (cnt_q != 2'd0));
    timeout  = wdog_run && (wdog_q == WDOG_LIMIT);

    if (wdog_run && (wdog_q != 20'hF_FFFF)) wdog_d = wdog_q + 20'd1;

    // Once a low request is seen, a post-abort request may be accepted again.
    if (!req_s_q) stale_d = 1'b0;

    if (timeout) begin
      state_d = WAIT_REQ;
      cnt_d   = '0;
      words_d = '0;
      wdog_d  = '0;
      ack_d   = 1'b0;
      err_d   = 1'b0 | 1'b1;
      // A request still high at abort time is stale and must not be captured.
      stale_d = req_s_q;
    end else begin
      unique case (state_q)
        WAIT_REQ: begin
          if (req_s_q && !stale_q) begin
            words_d[cnt_q] = data_s_q;
            ack_d          = 1'b1;
            wdog_d         = '0;
            state_d        = WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (!req_s_q) begin
            ack_d  = 1'b0;
            wdog_d = '0;
            if (cnt_q == 2'd3) begin
              // Fields and pulses are registered on entry so they are
              // visible during the single DONE cycle.
              state_d = DONE;
              if (words_q[0][5:2] == RST_TYPE) begin
                rstp_d = 1'b1;
              end else begin
                en_d       = 1'b1;
                msg_type_d = words_q[0][5:2];
                move_dir_d = words_q[0][1];
                block_y_d  = words_q[1][5:3];
                sel_len_d  = words_q[1][2:0];
                card_d     = words_q[2];
                block_x_d  = words_q[3][5:1];
              end
            end else begin
              cnt_d   = cnt_q + 2'd1;
              state_d = WAIT_REQ;
            end
          end
        end
        DONE: begin
          cnt_d   = '0;
          wdog_d  = '0;
          state_d = WAIT_REQ;
        end
        default: state_d = WAIT_REQ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    ack                 = ack_q;
    interboard_en       = en_q;
    interboard_rst      = rstp_q;
    rx_error            = err_q;
    interboard_msg_type = msg_type_q;
    interboard_move_dir = move_dir_q;
    interboard_block_x  = block_x_q;
    interboard_block_y  = block_y_q;
    interboard_card     = card_q;
    interboard_sel_len  = sel_len_q;
  end

endmodule

// File: tb/tb_interboard_receiver.sv
// ---------------------------------------------------------------------------
// tb_interboard_receiver
//   Directed bench for interboard_receiver (TIMEOUT=100): reset state, normal
//   decode, remote-reset message, watchdog abort, long request holds, reset
//   mid-message and back-to-back messages.
// ---------------------------------------------------------------------------
module tb_interboard_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       request;
  logic [5:0] interboard_data;
  logic       ack, interboard_en, interboard_rst, rx_error, interboard_move_dir;
  logic [3:0] interboard_msg_type;
  logic [4:0] interboard_block_x;
  logic [2:0] interboard_block_y, interboard_sel_len;
  logic [5:0] interboard_card;

  interboard_receiver #(.TIMEOUT(100), .RST_TYPE(4'hF)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .request             (request),
    .interboard_data     (interboard_data),
    .ack                 (ack),
    .interboard_en       (interboard_en),
    .interboard_rst      (interboard_rst),
    .interboard_msg_type (interboard_msg_type),
    .interboard_move_dir (interboard_move_dir),
    .interboard_block_x  (interboard_block_x),
    .interboard_block_y  (interboard_block_y),
    .interboard_card     (interboard_card),
    .interboard_sel_len  (interboard_sel_len),
    .rx_error            (rx_error)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int en_cnt = 0, rstp_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic en_at_fall, rst_at_fall, ack_dropped;
  int n;

  // Pulse monitor
  always @(negedge clk) begin
    if (interboard_en)                   en_cnt++;
    if (interboard_rst)                  rstp_cnt++;
    if (rx_error)                        err_cnt++;
    if (interboard_en && interboard_rst) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(input logic lvl, input string tag);
    int k = 0;
    while (ack !== lvl && k < 400) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(ack), 32'(lvl));
  endtask

  task automatic send_word(input logic [5:0] d, input int hold);
    wait_ack(1'b0, "ack_idle");
    interboard_data = d;
    request = 1'b1;
    wait_ack(1'b1, "ack_rise");
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (ack !== 1'b1) ack_dropped = 1'b1;
    end
    request = 1'b0;
    wait_ack(1'b0, "ack_fall");
    en_at_fall  = interboard_en;
    rst_at_fall = interboard_rst;
  endtask

  task automatic send_msg(input logic [5:0] w0, w1, w2, w3, input int hold);
    send_word(w0, hold);
    send_word(w1, hold);
    send_word(w2, hold);
    send_word(w3, hold);
  endtask

  task automatic check_fields(input string tag, input logic [3:0] t, input logic dir,
                              input logic [2:0] y, input logic [2:0] sel,
                              input logic [5:0] card, input logic [4:0] x);
    check({tag, ".type"}, 32'(interboard_msg_type), 32'(t));
    check({tag, ".dir"},  32'(interboard_move_dir), 32'(dir));
    check({tag, ".y"},    32'(interboard_block_y),  32'(y));
    check({tag, ".sel"},  32'(interboard_sel_len),  32'(sel));
    check({tag, ".card"}, 32'(interboard_card),     32'(card));
    check({tag, ".x"},    32'(interboard_block_x),  32'(x));
  endtask

  initial begin
    rst = 1'b1;
    request = 1'b0;
    interboard_data = '0;
    ack_dropped = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.ack", 32'(ack), 0);
    check("rst.en",  32'(interboard_en), 0);
    check("rst.rstp", 32'(interboard_rst), 0);
    check("rst.err", 32'(rx_error), 0);
    check_fields("rst", 4'd0, 1'b0, 3'd0, 3'd0, 6'd0, 5'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Message A: type 3, dir 1, y 5, sel 2, card 42, x 17
    send_msg(6'h0E, 6'h2A, 6'h2A, 6'h22, 2);
    check("A.en_latency", 32'(en_at_fall), 1);
    check("A.rstp", 32'(rst_at_fall), 0);
    check_fields("A", 4'd3, 1'b1, 3'd5, 3'd2, 6'd42, 5'd17);
    repeat (2) @(negedge clk);
    check("A.en_cnt", en_cnt, 1);

    // Remote reset message: fields retained
    send_msg(6'h3C, 6'h00, 6'h00, 6'h00, 2);
    check("R.rstp", 32'(rst_at_fall), 1);
    check("R.en", 32'(en_at_fall), 0);
    check_fields("R", 4'd3, 1'b1, 3'd5, 3'd2, 6'd42, 5'd17);
    repeat (2) @(negedge clk);
    check("R.en_cnt", en_cnt, 1);
    check("R.rstp_cnt", rstp_cnt, 1);

    // Watchdog: two words then silence
    send_word(6'h14, 2);
    send_word(6'h17, 2);
    n = 0;
    while (!rx_error && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("T.delay", n, 100);
    check("T.ack", 32'(ack), 0);
    repeat (2) @(negedge clk);
    check("T.err_cnt", err_cnt, 1);
    check("T.en_cnt", en_cnt, 1);
    // Message B after abort: type 5, dir 0, y 2, sel 7, card 63, x 31
    send_msg(6'h14, 6'h17, 6'h3F, 6'h3E, 2);
    check("B.en", 32'(en_at_fall), 1);
    check_fields("B", 4'd5, 1'b0, 3'd2, 3'd7, 6'd63, 5'd31);

    // Long holds: type A, dir 1, y 3, sel 1, card 7, x 9
    ack_dropped = 1'b0;
    send_msg(6'h2A, 6'h19, 6'h07, 6'h12, 50);
    check("H.ack_held", 32'(ack_dropped), 0);
    check("H.en", 32'(en_at_fall), 1);
    check_fields("H", 4'hA, 1'b1, 3'd3, 3'd1, 6'd7, 5'd9);
    repeat (2) @(negedge clk);
    check("H.en_cnt", en_cnt, 3);
    check("H.err_cnt", err_cnt, 1);

    // Reset during WAIT_REL of word 2
    send_word(6'h3E, 2);
    send_word(6'h3F, 2);
    wait_ack(1'b0, "X.ack_idle");
    interboard_data = 6'h15;
    request = 1'b1;
    wait_ack(1'b1, "X.ack_rise");
    rst = 1'b1;
    #1;
    check("X.ack_async", 32'(ack), 0);
    request = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("X.en_cnt", en_cnt, 3);
    check("X.rstp_cnt", rstp_cnt, 1);
    check("X.card_cleared", 32'(interboard_card), 0);
    send_msg(6'h0E, 6'h2A, 6'h2A, 6'h22, 2);
    check("X.en", 32'(en_at_fall), 1);
    check_fields("X", 4'd3, 1'b1, 3'd5, 3'd2, 6'd42, 5'd17);

    // Back-to-back, zero idle
    // C: type 1, dir 0, y 7, sel 0, card 5, x 2 ; D: type 8, dir 1, y 0, sel 4, card 56, x 30
    send_msg(6'h04, 6'h38, 6'h05, 6'h04, 0);
    check("C.en", 32'(en_at_fall), 1);
    check_fields("C", 4'd1, 1'b0, 3'd7, 3'd0, 6'd5, 5'd2);
    send_msg(6'h22, 6'h04, 6'h38, 6'h3C, 0);
    check("D.en", 32'(en_at_fall), 1);
    check_fields("D", 4'd8, 1'b1, 3'd0, 3'd4, 6'd56, 5'd30);
    repeat (3) @(negedge clk);
    check("D.en_cnt", en_cnt, 6);
    check("both_high", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
